// File: rtl/ram_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter_pkg
// Description : Shared types and constants for the log RAM access arbiter.
//               Contains the FSM state encoding (3 bits), the round-robin
//               grant side encoding, the one-hot grant vector type and the
//               default widths and RAM depth.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_access_arbiter_pkg;

    localparam int c_addr_width = 16;
    localparam int c_data_width = 37;
    localparam int c_depth      = 256;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_READ1   = 3'd2,
        ST_READ2   = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_DONE_RD = 3'd5
    } arb_state_e;

    // Side that won the most recent read/write arbitration
    typedef enum logic {
        GRANT_WR = 1'b0,
        GRANT_RD = 1'b1
    } grant_e;

    // One-hot grant produced by the round-robin picker
    typedef struct packed {
        logic wr;
        logic rd;
    } grant_oh_t;

endpackage : ram_access_arbiter_pkg
`default_nettype wire

// File: rtl/ram_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter_if
// Description : Bundles the requester handshakes and the RAM control bus of
//               the log RAM arbiter.
//               slave  : arbiter view (takes requests, drives done/RAM pins)
//               master : environment view (requesters plus the RAM itself)
//               Signals: wr_req/wr_addr/wr_data/wr_done, rd_req/rd_addr/
//               rd_data/rd_done, clr_req/clr_done, addr_err, ram_we/ram_re/
//               ram_clr, ram_wr_addr/ram_wr_data/ram_rd_addr, ram_rd_data.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_access_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 37
);
    // writer
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_done;
    // reader
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_done;
    // clear requester
    logic                  clr_req;
    logic                  clr_done;
    // status
    logic                  addr_err;
    // RAM side
    logic                  ram_we;
    logic                  ram_re;
    logic                  ram_clr;
    logic [ADDR_WIDTH-1:0] ram_wr_addr;
    logic [DATA_WIDTH-1:0] ram_wr_data;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    modport slave (
        input  wr_req, wr_addr, wr_data,
        input  rd_req, rd_addr,
        input  clr_req,
        input  ram_rd_data,
        output wr_done, rd_done, rd_data, clr_done, addr_err,
        output ram_we, ram_re, ram_clr,
        output ram_wr_addr, ram_wr_data, ram_rd_addr
    );

    modport master (
        output wr_req, wr_addr, wr_data,
        output rd_req, rd_addr,
        output clr_req,
        output ram_rd_data,
        input  wr_done, rd_done, rd_data, clr_done, addr_err,
        input  ram_we, ram_re, ram_clr,
        input  ram_wr_addr, ram_wr_data, ram_rd_addr
    );

endinterface : ram_access_arbiter_if
`default_nettype wire

// File: rtl/ram_access_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_rr_pick
// Description : Combinational two-way round-robin picker between the writer
//               and the reader. When both request, the side that did not win
//               last time is granted; otherwise the lone requester wins.
//   wr_req     in  writer request
//   rd_req     in  reader request
//   last_grant in  side granted most recently
//   grant      out one-hot grant {wr, rd}; all-zero when nobody requests
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arb_rr_pick
    import ram_access_arbiter_pkg::*;
(
    input  logic      wr_req,
    input  logic      rd_req,
    input  grant_e    last_grant,
    output grant_oh_t grant
);

    always_comb begin
        grant = '0;
        if (wr_req && rd_req) begin
            if (last_grant == GRANT_RD) begin
                grant.wr = 1'b1;
            end else begin
                grant.rd = 1'b1;
            end
        end else begin
            grant.wr = wr_req;
            grant.rd = rd_req;
        end
    end

endmodule : ram_arb_rr_pick
`default_nettype wire

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_access_arbiter
// Description : Sequences every access to the shared single-clock log RAM
//               (1-cycle registered read, whole-array clear). Arbitrates a
//               writer, a reader and a clear requester over valid/done
//               handshakes and owns all RAM control pins, so we/re/clr are
//               mutually exclusive. Out-of-range addresses are answered with
//               done + addr_err and never reach the RAM.
//   clk   in  single clock, all state changes on posedge
//   rst_n in  asynchronous active-low reset
//   bus   slave modport of ram_access_arbiter_if (requests, done pulses,
//         read data, address error, RAM control/address/data pins)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_access_arbiter
    import ram_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = c_addr_width,
    parameter int DATA_WIDTH = c_data_width,
    parameter int DEPTH      = c_depth
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_access_arbiter_if.slave    bus
);

    // One extra bit so a DEPTH of 2**ADDR_WIDTH does not truncate to zero;
    // the compare stays unsigned over the full address width.
    localparam logic [ADDR_WIDTH:0] c_depth_ext = (ADDR_WIDTH + 1)'(DEPTH);

    arb_state_e            r_state;
    grant_e                r_last_grant;

    logic                  r_ram_we;
    logic                  r_ram_re;
    logic                  r_ram_clr;
    logic                  r_wr_done;
    logic                  r_rd_done;
    logic                  r_clr_done;
    logic                  r_addr_err;
    logic [ADDR_WIDTH-1:0] r_ram_wr_addr;
    logic [DATA_WIDTH-1:0] r_ram_wr_data;
    logic [ADDR_WIDTH-1:0] r_ram_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    grant_oh_t             w_grant;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;

    assign w_wr_in_range = ({1'b0, bus.wr_addr} < c_depth_ext);
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < c_depth_ext);

    ram_arb_rr_pick u_rr_pick (
        .wr_req     (bus.wr_req),
        .rd_req     (bus.rd_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // ------------------------------------------------------------------------
    // Sequencer. Every output is a register loaded together with the state it
    // belongs to, so the RAM pins are a clean function of the state entered
    // and the async reset clears them immediately. A rejected write still
    // passes through WRITE (to emit its done pulse) with ram_we held low; a
    // rejected read jumps straight to DONE_RD.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= GRANT_RD;
            r_ram_we      <= 1'b0;
            r_ram_re      <= 1'b0;
            r_ram_clr     <= 1'b0;
            r_wr_done     <= 1'b0;
            r_rd_done     <= 1'b0;
            r_clr_done    <= 1'b0;
            r_addr_err    <= 1'b0;
            r_ram_wr_addr <= '0;
            r_ram_wr_data <= '0;
            r_ram_rd_addr <= '0;
            r_rd_data     <= '0;
        end else begin
            // single-cycle pulses fall unless the next state re-asserts them
            r_ram_we   <= 1'b0;
            r_ram_re   <= 1'b0;
            r_ram_clr  <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rd_done  <= 1'b0;
            r_clr_done <= 1'b0;
            r_addr_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        // clear has absolute priority and leaves round robin alone
                        r_state    <= ST_CLEAR;
                        r_ram_clr  <= 1'b1;
                        r_clr_done <= 1'b1;
                    end else if (w_grant.wr) begin
                        r_last_grant  <= GRANT_WR;
                        r_ram_wr_addr <= bus.wr_addr;
                        r_ram_wr_data <= bus.wr_data;
                        r_state       <= ST_WRITE;
                        r_wr_done     <= 1'b1;
                        if (w_wr_in_range) begin
                            r_ram_we <= 1'b1;
                        end else begin
                            r_addr_err <= 1'b1;
                        end
                    end else if (w_grant.rd) begin
                        r_last_grant  <= GRANT_RD;
                        r_ram_rd_addr <= bus.rd_addr;
                        if (w_rd_in_range) begin
                            r_state  <= ST_READ1;
                            r_ram_re <= 1'b1;
                        end else begin
                            r_state    <= ST_DONE_RD;
                            r_rd_done  <= 1'b1;
                            r_addr_err <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    r_state <= ST_IDLE;
                end

                ST_READ1: begin
                    // RAM samples the address at the end of this cycle
                    r_state  <= ST_READ2;
                    r_ram_re <= 1'b1;
                end

                ST_READ2: begin
                    // registered RAM output is valid now; capture it
                    r_state   <= ST_DONE_RD;
                    r_rd_done <= 1'b1;
                    r_rd_data <= bus.ram_rd_data;
                end

                ST_DONE_RD: begin
                    r_state <= ST_IDLE;
                end

                ST_CLEAR: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_we      = r_ram_we;
    assign bus.ram_re      = r_ram_re;
    assign bus.ram_clr     = r_ram_clr;
    assign bus.wr_done     = r_wr_done;
    assign bus.rd_done     = r_rd_done;
    assign bus.clr_done    = r_clr_done;
    assign bus.addr_err    = r_addr_err;
    assign bus.ram_wr_addr = r_ram_wr_addr;
    assign bus.ram_wr_data = r_ram_wr_data;
    assign bus.ram_rd_addr = r_ram_rd_addr;
    assign bus.rd_data     = r_rd_data;

endmodule : ram_access_arbiter
`default_nettype wire

// File: tb/tb_ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_access_arbiter
// Description : Self-checking bench for ram_access_arbiter. Contains a
//               registered-read RAM model, requester agents and a
//               transaction-level reference model that schedules the
//               expected per-cycle outputs from the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_access_arbiter;
    import ram_access_arbiter_pkg::*;

    localparam int AW   = 16;
    localparam int DW   = 37;
    localparam int DEP  = 256;
    localparam int MAXC = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ram_init;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- RAM model: registered read, whole-array clear --------
    logic [DW-1:0] ram_mem [0:DEP-1];
    logic [DW-1:0] ram_q;

    always @(posedge clk) begin
        if (ram_init || bus.ram_clr) begin
            for (int i = 0; i < DEP; i++) ram_mem[i] <= '0;
            if (ram_init) ram_q <= '0;
        end else if (bus.ram_we && bus.ram_wr_addr < AW'(DEP)) begin
            ram_mem[bus.ram_wr_addr[7:0]] <= bus.ram_wr_data;
        end
        if (!ram_init && bus.ram_re && bus.ram_rd_addr < AW'(DEP))
            ram_q <= ram_mem[bus.ram_rd_addr[7:0]];
    end
    assign bus.ram_rd_data = (bus.ram_re && !bus.ram_we) ? ram_q : '0;

    // ---------------- reference model --------------------------------------
    typedef struct packed {
        logic          we, re, clr, wd, rdn, cd, err;
        logic [AW-1:0] wa;
        logic [DW-1:0] wdat;
        logic [AW-1:0] ra;
    } exp_t;

    exp_t          exp_tab [0:MAXC-1];
    logic [DW-1:0] ref_mem [0:DEP-1];
    logic [DW-1:0] ref_rdd, pend_rdd;
    int            pend_cyc;
    int            free_at;
    bit            last_rd;          // 1: reader won most recently
    int            p_wr, p_rd, p_clr;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, expv);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({bus.ram_we, bus.ram_re, bus.ram_clr, bus.wr_done, bus.rd_done,
                     bus.clr_done, bus.addr_err, bus.ram_wr_addr, bus.ram_wr_data,
                     bus.ram_rd_addr, bus.rd_data});
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = int'($urandom_range(99));
        if (r < 8)  return AW'($urandom_range(65535, 256));
        if (r < 14) return (r < 11) ? AW'(255) : AW'(256);
        return AW'($urandom_range(255));
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // Schedule expected outputs for an operation granted in cycle g.
    task automatic arbitrate(input int g);
        int i1, i2, i3;
        i1 = (g + 1) % MAXC;
        i2 = (g + 2) % MAXC;
        i3 = (g + 3) % MAXC;
        if (bus.clr_req) begin
            exp_tab[i1].clr = 1'b1;
            exp_tab[i1].cd  = 1'b1;
            for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
            free_at = g + 2;
        end else if (bus.wr_req && (!bus.rd_req || last_rd)) begin
            last_rd = 1'b0;
            exp_tab[i1].wd = 1'b1;
            if (int'(bus.wr_addr) < DEP) begin
                exp_tab[i1].we   = 1'b1;
                exp_tab[i1].wa   = bus.wr_addr;
                exp_tab[i1].wdat = bus.wr_data;
                ref_mem[bus.wr_addr[7:0]] = bus.wr_data;
            end else begin
                exp_tab[i1].err = 1'b1;
            end
            free_at = g + 2;
        end else if (bus.rd_req) begin
            last_rd = 1'b1;
            if (int'(bus.rd_addr) < DEP) begin
                exp_tab[i1].re  = 1'b1;
                exp_tab[i1].ra  = bus.rd_addr;
                exp_tab[i2].re  = 1'b1;
                exp_tab[i2].ra  = bus.rd_addr;
                exp_tab[i3].rdn = 1'b1;
                pend_rdd = ref_mem[bus.rd_addr[7:0]];
                pend_cyc = g + 3;
                free_at  = g + 4;
            end else begin
                exp_tab[i1].rdn = 1'b1;
                exp_tab[i1].err = 1'b1;
                free_at = g + 2;
            end
        end
    endtask

    // Sample outputs mid-cycle, compare, and retire requests on their done.
    task automatic observe();
        exp_t e;
        int   c;
        @(negedge clk);
        c = cyc % MAXC;
        e = exp_tab[c];
        if (cyc == pend_cyc) begin
            ref_rdd  = pend_rdd;
            pend_cyc = -1;
        end
        check_val("ctl", 128'({bus.ram_we, bus.ram_re, bus.ram_clr, bus.wr_done,
                               bus.rd_done, bus.clr_done, bus.addr_err}),
                         128'({e.we, e.re, e.clr, e.wd, e.rdn, e.cd, e.err}));
        check_val("rd_data", 128'(bus.rd_data), 128'(ref_rdd));
        if (e.we) check_val("ram_wr", 128'({bus.ram_wr_addr, bus.ram_wr_data}), 128'({e.wa, e.wdat}));
        if (e.re) check_val("ram_rd_addr", 128'(bus.ram_rd_addr), 128'(e.ra));
        exp_tab[c] = '0;
        if (e.wd)  bus.wr_req  = 1'b0;
        if (e.rdn) bus.rd_req  = 1'b0;
        if (e.cd)  bus.clr_req = 1'b0;
    endtask

    // Raise new random requests, then let the model arbitrate this cycle.
    task automatic commit();
        if (!bus.wr_req && int'($urandom_range(99)) < p_wr) begin
            bus.wr_req  = 1'b1;
            bus.wr_addr = rand_addr();
            bus.wr_data = rand_data();
        end
        if (!bus.rd_req && int'($urandom_range(99)) < p_rd) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = rand_addr();
        end
        if (!bus.clr_req && int'($urandom_range(99)) < p_clr) bus.clr_req = 1'b1;
        if (cyc >= free_at) arbitrate(cyc);
    endtask

    task automatic tick();
        observe();
        commit();
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (bus.wr_req || bus.rd_req || bus.clr_req); i++) tick();
        if (bus.wr_req || bus.rd_req || bus.clr_req) begin
            check_val("drain_timeout", 128'(1), 128'(0));
            bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.clr_req = 1'b0;
        end
    endtask

    task automatic do_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        observe();
        bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        commit();
        drain();
    endtask

    task automatic do_rd(input logic [AW-1:0] a);
        observe();
        bus.rd_req = 1'b1; bus.rd_addr = a;
        commit();
        drain();
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic reset_mid();
        #1 rst_n = 1'b0;
        #1 check_val("reset_outs", all_outs(), 128'(0));
        bus.wr_req = 1'b0; bus.rd_req = 1'b0; bus.clr_req = 1'b0;
        for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
        ref_rdd  = '0;
        pend_cyc = -1;
        last_rd  = 1'b1;
        repeat (2) @(negedge clk);
        check_val("reset_hold", all_outs(), 128'(0));
        rst_n   = 1'b1;
        free_at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0; bus.clr_req = 1'b0;
        ram_init = 1'b1;
        p_wr = 0; p_rd = 0; p_clr = 0;
        for (int i = 0; i < MAXC; i++) exp_tab[i] = '0;
        for (int i = 0; i < DEP; i++) ref_mem[i] = '0;
        ref_rdd = '0; pend_rdd = '0; pend_cyc = -1; last_rd = 1'b1; free_at = 0;

        repeat (3) @(negedge clk);
        check_val("reset_state", all_outs(), 128'(0));
        ram_init = 1'b0;
        rst_n    = 1'b1;
        free_at  = cyc;

        // write then read back address 5
        do_wr(16'd5, 37'h1_2345_6789);
        do_rd(16'd5);

        // both requesters held from reset: writer first, then alternate
        reset_mid();
        p_wr = 100; p_rd = 100;
        repeat (24) tick();
        p_wr = 0; p_rd = 0;
        drain();

        // clear raised while a read is in READ1
        do_wr(16'd5, 37'h1_2345_6789);
        observe();
        bus.rd_req = 1'b1; bus.rd_addr = 16'd5;
        commit();
        observe();
        bus.clr_req = 1'b1;
        commit();
        drain();
        do_rd(16'd5);

        // out-of-range write, then boundary read
        do_wr(16'd256, 37'h0_DEAD_BEEF);
        do_wr(16'd255, 37'h1_0000_0001);
        do_rd(16'd255);
        do_rd(16'hFFFF);

        // reset during READ2, then normal operation resumes
        observe();
        bus.rd_req = 1'b1; bus.rd_addr = 16'd255;
        commit();
        tick();
        observe();
        reset_mid();
        do_wr(16'd7, 37'h0_0BAD_CAFE);
        do_rd(16'd7);
        do_rd(16'd255);

        // randomized traffic
        p_wr = 35; p_rd = 35; p_clr = 4;
        repeat (2000) tick();
        p_wr = 0; p_rd = 0; p_clr = 0;
        drain();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_ram_access_arbiter
`default_nettype wire
